// File: rtl/pwm_fault_guard.sv
// pwm_fault_guard: fault qualification and trip control for the PWM bridge.
// Over-current and over-voltage comparators are synchronised and
// glitch-filtered. The external trip acts directly. A qualified fault forces
// `protection` high and records its cause in a sticky code.
//
// Optional feature macro: PWM_FAULT_GUARD_RETRY_EN
//   defined     - a trip in RUN enters WAIT. The hold-off timer then restarts
//                 the bridge up to RETRY_MAX times before LOCK.
//   not defined - a trip in RUN goes straight to LOCK. No WAIT state and no
//                 timer are built, and retry_cnt is tied to zero.
module pwm_fault_guard #(
  parameter int FILT_W    = 8,
  parameter int RETRY_MAX = 3,
  parameter int RC_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              oc_in,
  input  logic              ov_in,
  input  logic              ext_trip,
  input  logic              clear,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [20:0]       retry_wait,
  output logic              protection,
  output logic [2:0]        fault_code,
  output logic [RC_W-1:0]   retry_cnt,
  output logic              locked,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  // True on the edge where this cycle's count would reach the filter length.
  // A length of 0 behaves like 1 because count+1 is always >= 1.
  function automatic logic filt_hit(input logic sync_v,
                                    input logic [FILT_W-1:0] cnt_v,
                                    input logic [FILT_W-1:0] len_v);
    logic [FILT_W:0] inc_v;
    inc_v = {1'b0, cnt_v} + {{FILT_W{1'b0}}, 1'b1};
    return sync_v & (inc_v >= {1'b0, len_v});
  endfunction

  // Saturating consecutive-high counter that clears on any low sample.
  function automatic logic [FILT_W-1:0] filt_next(input logic sync_v,
                                                  input logic [FILT_W-1:0] cnt_v);
    logic [FILT_W-1:0] res_v;
    if (!sync_v) begin
      res_v = {FILT_W{1'b0}};
    end else if (&cnt_v) begin
      res_v = cnt_v;
    end else begin
      res_v = cnt_v + {{(FILT_W-1){1'b0}}, 1'b1};
    end
    return res_v;
  endfunction

  logic              oc_meta_r, oc_sync_r, ov_meta_r, ov_sync_r;
  logic [FILT_W-1:0] oc_cnt_r, ov_cnt_r;
  logic              oc_q_s, ov_q_s, ext_q_s, any_q_s;
  logic [2:0]        new_bits_s;

  state_t            state_r, state_n_s;
  logic [2:0]        fault_code_r, fault_code_n_s;
  logic              protection_r, locked_r;

  // Two-flop synchronisers for the asynchronous comparator inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_meta_r <= 1'b0;
      oc_sync_r <= 1'b0;
      ov_meta_r <= 1'b0;
      ov_sync_r <= 1'b0;
    end else begin
      oc_meta_r <= oc_in;
      oc_sync_r <= oc_meta_r;
      ov_meta_r <= ov_in;
      ov_sync_r <= ov_meta_r;
    end
  end

  // Glitch-filter counters, one per synchronised comparator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_cnt_r <= {FILT_W{1'b0}};
      ov_cnt_r <= {FILT_W{1'b0}};
    end else begin
      oc_cnt_r <= filt_next(oc_sync_r, oc_cnt_r);
      ov_cnt_r <= filt_next(ov_sync_r, ov_cnt_r);
    end
  end

  assign oc_q_s     = filt_hit(oc_sync_r, oc_cnt_r, filt_len);
  assign ov_q_s     = filt_hit(ov_sync_r, ov_cnt_r, filt_len);
  assign ext_q_s    = ext_trip;
  assign any_q_s    = oc_q_s | ov_q_s | ext_q_s;
  assign new_bits_s = {ext_q_s, ov_q_s, oc_q_s};

`ifdef PWM_FAULT_GUARD_RETRY_EN
  logic [RC_W-1:0] retry_cnt_r, retry_cnt_n_s;
  logic [20:0]     timer_r, timer_n_s, timer_load_s;

  // A programmed hold-off of 0 is treated as a single cycle.
  assign timer_load_s = (retry_wait == 21'd0) ? 21'd1 : retry_wait;
`else
  logic unused_retry_s;

  assign unused_retry_s = ^{retry_wait, RC_W'(RETRY_MAX)};
`endif

  // Next-state and sticky-status decisions: fault > clear > enable.
  always_comb begin
    state_n_s      = state_r;
    fault_code_n_s = fault_code_r;
`ifdef PWM_FAULT_GUARD_RETRY_EN
    retry_cnt_n_s  = retry_cnt_r;
    timer_n_s      = timer_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          fault_code_n_s = 3'b000;
        end else begin
          fault_code_n_s = fault_code_r;
        end
        if (enable && !any_q_s) begin
          state_n_s = ST_RUN;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (any_q_s) begin
          fault_code_n_s = fault_code_r | new_bits_s;
`ifdef PWM_FAULT_GUARD_RETRY_EN
          timer_n_s      = timer_load_s;
          state_n_s      = ST_WAIT;
`else
          state_n_s      = ST_LOCK;
`endif
        end else begin
          if (clear) begin
            fault_code_n_s = 3'b000;
          end else begin
            fault_code_n_s = fault_code_r;
          end
          if (!enable) begin
            state_n_s = ST_IDLE;
`ifdef PWM_FAULT_GUARD_RETRY_EN
            retry_cnt_n_s = {RC_W{1'b0}};
`endif
          end else begin
            state_n_s = ST_RUN;
          end
        end
      end
`ifdef PWM_FAULT_GUARD_RETRY_EN
      ST_WAIT: begin
        fault_code_n_s = fault_code_r | new_bits_s;
        if (any_q_s) begin
          timer_n_s = timer_load_s;
          state_n_s = ST_WAIT;
        end else if (clear) begin
          fault_code_n_s = 3'b000;
          retry_cnt_n_s  = {RC_W{1'b0}};
          state_n_s      = ST_IDLE;
        end else if (!enable) begin
          retry_cnt_n_s = {RC_W{1'b0}};
          state_n_s     = ST_IDLE;
        end else if (timer_r <= 21'd1) begin
          if (retry_cnt_r < RC_W'(RETRY_MAX)) begin
            retry_cnt_n_s = retry_cnt_r + {{(RC_W-1){1'b0}}, 1'b1};
            state_n_s     = ST_RUN;
          end else begin
            state_n_s = ST_LOCK;
          end
        end else begin
          timer_n_s = timer_r - 21'd1;
          state_n_s = ST_WAIT;
        end
      end
`endif
      ST_LOCK: begin
        if (clear && !any_q_s) begin
          fault_code_n_s = 3'b000;
`ifdef PWM_FAULT_GUARD_RETRY_EN
          retry_cnt_n_s  = {RC_W{1'b0}};
`endif
          state_n_s      = ST_IDLE;
        end else begin
          state_n_s = ST_LOCK;
        end
      end
      // Unbuilt or corrupted encodings fall to the safe, latched-off state.
      default: begin
        state_n_s = ST_LOCK;
      end
    endcase
  end

  // State, sticky cause and registered bridge-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      fault_code_r <= 3'b000;
      protection_r <= 1'b1;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      fault_code_r <= fault_code_n_s;
      protection_r <= (state_n_s != ST_RUN);
      locked_r     <= (state_n_s == ST_LOCK);
    end
  end

`ifdef PWM_FAULT_GUARD_RETRY_EN
  // Retry bookkeeping and hold-off timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt_r <= {RC_W{1'b0}};
      timer_r     <= 21'd0;
    end else begin
      retry_cnt_r <= retry_cnt_n_s;
      timer_r     <= timer_n_s;
    end
  end

  assign retry_cnt = retry_cnt_r;
`else
  assign retry_cnt = {RC_W{1'b0}};
`endif

  assign protection = protection_r;
  assign fault_code = fault_code_r;
  assign locked     = locked_r;
  assign state      = state_r;

endmodule

// File: tb/tb_pwm_fault_guard.sv
// Scoreboard bench for pwm_fault_guard. The stimulus pushes the expected
// output vector after each edge of interest. The monitor pops it and compares
// on the following falling edge. It works with or without
// PWM_FAULT_GUARD_RETRY_EN.
module tb_pwm_fault_guard;

  localparam int FILT_W    = 8;
  localparam int RETRY_MAX = 3;
  localparam int RC_W      = 2;

`ifdef PWM_FAULT_GUARD_RETRY_EN
  localparam logic [1:0] TRIP_ST = 2'd2;
  localparam logic       TRIP_LK = 1'b0;
  localparam logic [1:0] LOCK_RC = 2'd3;
`else
  localparam logic [1:0] TRIP_ST = 2'd3;
  localparam logic       TRIP_LK = 1'b1;
  localparam logic [1:0] LOCK_RC = 2'd0;
`endif

  logic              clk;
  logic              rst;
  logic              enable;
  logic              oc_in;
  logic              ov_in;
  logic              ext_trip;
  logic              clear;
  logic [FILT_W-1:0] filt_len;
  logic [20:0]       retry_wait;
  logic              protection;
  logic [2:0]        fault_code;
  logic [RC_W-1:0]   retry_cnt;
  logic              locked;
  logic [1:0]        state;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pwm_fault_guard #(
    .FILT_W    (FILT_W),
    .RETRY_MAX (RETRY_MAX),
    .RC_W      (RC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .oc_in      (oc_in),
    .ov_in      (ov_in),
    .ext_trip   (ext_trip),
    .clear      (clear),
    .filt_len   (filt_len),
    .retry_wait (retry_wait),
    .protection (protection),
    .fault_code (fault_code),
    .retry_cnt  (retry_cnt),
    .locked     (locked),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] pack(input logic p, input logic [1:0] st,
                                      input logic [2:0] fc, input logic [1:0] rc,
                                      input logic lk);
    return {p, st, fc, rc, lk};
  endfunction

  task automatic expect_out(input string name, input logic [8:0] v);
    exp_t e;
    e.name = name;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every pending expectation against the live outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = sb_q.pop_front();
      act = {protection, state, fault_code, retry_cnt, locked};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got prot=%0b state=%0d code=%03b retry=%0d locked=%0b, expected prot=%0b state=%0d code=%03b retry=%0d locked=%0b",
                 e.name, act[8], act[7:6], act[5:3], act[2:1], act[0],
                 e.exp[8], e.exp[7:6], e.exp[5:3], e.exp[2:1], e.exp[0]);
      end
    end
  end

  // Stimulus with hand-computed expectations.
  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    oc_in      = 1'b0;
    ov_in      = 1'b0;
    ext_trip   = 1'b0;
    clear      = 1'b0;
    filt_len   = 8'd4;
    retry_wait = 21'd100;

    tick(2);
    expect_out("reset", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    rst = 1'b0;
    tick(1);
    expect_out("idle_no_enable", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    enable = 1'b1;
    tick(1);
    expect_out("run_entry", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

    // A 3-cycle oc pulse with filt_len=4 must not trip.
    oc_in = 1'b1;
    tick(3);
    oc_in = 1'b0;
    tick(6);
    expect_out("oc_glitch", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

    // A sustained oc: no trip through edge k+4, trip at edge k+5.
    oc_in = 1'b1;
    tick(5);
    expect_out("oc_before_trip", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));
    tick(1);
    expect_out("oc_trip", pack(1'b1, TRIP_ST, 3'b001, 2'd0, TRIP_LK));

    // A clear while oc is still qualified is ignored.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("clear_ignored", pack(1'b1, TRIP_ST, 3'b001, 2'd0, TRIP_LK));

    // Once oc has drained through the synchroniser, clear returns to IDLE.
    oc_in = 1'b0;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("clear_to_idle", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    tick(1);
    expect_out("rerun", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

    // ov and ext qualify on the same edge.
    ov_in = 1'b1;
    tick(5);
    ext_trip = 1'b1;
    expect_out("ov_before_trip", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));
    tick(1);
    ext_trip = 1'b0;
    ov_in    = 1'b0;
    expect_out("ov_ext_trip", pack(1'b1, TRIP_ST, 3'b110, 2'd0, TRIP_LK));
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("clear2_to_idle", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    tick(1);
    expect_out("rerun2", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

`ifdef PWM_FAULT_GUARD_RETRY_EN
    // Three timed restarts, then LOCK on the fourth timeout.
    for (int i = 0; i < 4; i++) begin
      ext_trip = 1'b1;
      tick(1);
      ext_trip = 1'b0;
      expect_out("retry_trip", pack(1'b1, 2'd2, 3'b100, 2'(i), 1'b0));
      tick(99);
      expect_out("retry_hold", pack(1'b1, 2'd2, 3'b100, 2'(i), 1'b0));
      tick(1);
      if (i < 3) begin
        expect_out("retry_restart", pack(1'b0, 2'd1, 3'b100, 2'(i + 1), 1'b0));
      end else begin
        expect_out("retry_lock", pack(1'b1, 2'd3, 3'b100, 2'd3, 1'b1));
      end
    end
`else
    ext_trip = 1'b1;
    tick(1);
    ext_trip = 1'b0;
    expect_out("ext_lock", pack(1'b1, 2'd3, 3'b100, 2'd0, 1'b1));
`endif

    // In LOCK, a clear with oc qualified is ignored.
    oc_in = 1'b1;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("lock_clear_ignored", pack(1'b1, 2'd3, 3'b100, LOCK_RC, 1'b1));
    oc_in = 1'b0;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("lock_clear", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    tick(1);
    expect_out("rerun3", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

    // Dropping enable in RUN returns to IDLE.
    enable = 1'b0;
    tick(1);
    expect_out("enable_drop", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));
    enable = 1'b1;
    tick(1);
    expect_out("rerun4", pack(1'b0, 2'd1, 3'b000, 2'd0, 1'b0));

    // Trip, then assert rst mid-cycle with no clock edge before the check.
    ext_trip = 1'b1;
    tick(1);
    ext_trip = 1'b0;
    expect_out("ext_trip", pack(1'b1, TRIP_ST, 3'b100, 2'd0, TRIP_LK));
    tick(1);
    rst = 1'b1;
    #1;
    expect_out("async_reset", pack(1'b1, 2'd0, 3'b000, 2'd0, 1'b0));

    tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
